seven_segment_monitor: RTL

Receive-side checker for a seven-segment display bus: samples a 7-bit segment pattern from the user I/O pads and synchronises it into `clk`. It filters glitches with a stability window, decodes the pattern back to a BCD digit and counts digit changes. It also optionally checks that digits advance 0→9→0. It sits in the user project next to the seven-segment driver, for loop-back self-test and for monitoring an external display bus.

---
 rtl/seven_segment_monitor.sv | 125 ++++++++++++
 1 files changed

// File: rtl/seven_segment_monitor.sv
// rtl/seven_segment_monitor.sv - seven-segment bus monitor: synchroniser, stability filter, BCD decode, change counter
// Define SEG_SEQ_CHECK_EN to build the 0->9->0 digit sequence checker.
module seven_segment_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [6:0]             seg_in,
  input  logic                   clear,
  output logic [3:0]             digit,
  output logic                   digit_valid,
  output logic                   bad_pattern,
  output logic                   update,
  output logic [COUNT_WIDTH-1:0] change_count,
  output logic                   seq_error,
  output logic [7:0]             seq_error_count
);

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

  logic [6:0] s1, s2, cand, acc;
  logic [7:0] cnt;
  logic       accept;
  logic       cand_valid, acc_valid;
  logic [3:0] cand_digit, acc_digit;

  // Returns {valid, digit}; digit is 0 for anything that is not a digit code.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
      default: decode = 5'd0;
    endcase
  endfunction

  assign accept = (s2 == cand) && (cnt == LAST_CNT) && (cand != acc);
  assign {cand_valid, cand_digit} = decode(cand);
  assign {acc_valid, acc_digit}   = decode(acc);

  assign digit       = acc_digit;
  assign digit_valid = acc_valid;
  assign bad_pattern = (acc != 7'h00) && !acc_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 7'h00;
      s2     <= 7'h00;
      cand   <= 7'h00;
      cnt    <= 8'd0;
      acc    <= 7'h00;
      update <= 1'b0;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
      // Any movement of the synchronised pattern restarts the stability window.
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= 8'd0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      update <= accept;
      if (accept) acc <= cand;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      change_count <= '0;
    end else if (clear) begin
      change_count <= '0;
    end else if (accept && (change_count != '1)) begin
      change_count <= change_count + COUNT_WIDTH'(1);
    end
  end

`ifdef SEG_SEQ_CHECK_EN
  typedef enum logic {NO_REF, HAVE_REF} seq_state_t;

  seq_state_t state;
  logic [3:0] prev;
  logic [3:0] next_expected;

  assign next_expected = (prev == 4'd9) ? 4'd0 : prev + 4'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= NO_REF;
      prev            <= 4'd0;
      seq_error       <= 1'b0;
      seq_error_count <= 8'd0;
    end else begin
      if (accept) begin
        if (cand_valid) begin
          prev  <= cand_digit;
          state <= HAVE_REF;
        end else begin
          state <= NO_REF;
        end
      end
      // clear only touches the error record; the reference digit survives it.
      if (clear) begin
        seq_error       <= 1'b0;
        seq_error_count <= 8'd0;
      end else if (accept && cand_valid && (state == HAVE_REF) && (cand_digit != next_expected)) begin
        seq_error <= 1'b1;
        if (seq_error_count != 8'hFF) seq_error_count <= seq_error_count + 8'd1;
      end
    end
  end
`else
  assign seq_error       = 1'b0;
  assign seq_error_count = 8'd0;
`endif

endmodule
